// File: rtl/cordic_iter_engine_if.sv
// Operand/result handshake bundle for the iterative CORDIC engine.
// The master side drives operands and the result ready; the slave side is the engine.
interface cordic_iter_engine_if #(
    parameter int W  = 16,
    parameter int AW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic signed [W-1:0]  x_in;
    logic signed [W-1:0]  y_in;
    logic signed [AW-1:0] z_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  x_out;
    logic signed [W-1:0]  y_out;
    logic signed [AW-1:0] z_out;
    logic                 busy;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, busy
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, busy
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: one micro-rotation per clock, rotation or vectoring mode.
// Results pass through an output register stage and are held until consumed.
module cordic_iter_engine #(
    parameter int W    = 16,
    parameter int AW   = 16,
    parameter int ITER = 14
) (
    input logic clk,
    input logic rst_n,
    cordic_iter_engine_if.slave io
);
    localparam int CW = $clog2(ITER + 1);
    localparam int TN = 1 << CW;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // atan(1/n) in Q60 by its power series, integer-only for elaboration
    function automatic logic [63:0] atan_inv(input logic [63:0] n);
        logic [63:0] term, sum, n2;
        term = (64'd1 << 60) / n;
        n2   = n * n;
        sum  = 64'd0;
        for (int k = 0; k < 48; k++) begin
            if (k[0]) sum = sum - term / 64'(2 * k + 1);
            else      sum = sum + term / 64'(2 * k + 1);
            term = (n2 == 64'd0) ? 64'd0 : term / n2;
        end
        return sum;
    endfunction

    // Machin's formula gives 2*pi in Q60; entry = round(atan * 2^AW / 2pi)
    function automatic logic [63:0] atan_entry(input int i);
        logic [63:0] two_pi, d, a;
        if (i == 0) return 64'd1 << (AW - 3);
        two_pi = (atan_inv(64'd5) << 5) - (atan_inv(64'd239) << 3);
        d      = two_pi >> AW;
        a      = atan_inv(64'd1 << i);
        return (a + (d >> 1)) / d;
    endfunction

    logic [AW-1:0] atan_tab [TN];

    for (genvar g = 0; g < TN; g++) begin : g_tab
        localparam logic [63:0] E = (g < ITER) ? atan_entry(g) : 64'd0;
        assign atan_tab[g] = E[AW-1:0];
    end

    logic [1:0]           state;
    logic                 rdy;
    logic                 mode_r;
    logic [CW-1:0]        i;
    logic signed [W-1:0]  x_r, y_r;
    logic [AW-1:0]        z_r;
    logic                 ov;
    logic signed [W-1:0]  x_o, y_o;
    logic signed [AW-1:0] z_o;

    logic                 flip;
    logic                 pos;
    logic signed [W-1:0]  xs, ys;
    logic [AW-1:0]        ang;

    // Fold the operand into the right half-plane so the iterations converge
    assign flip = io.mode ? io.x_in[W-1]
                          : (io.z_in[AW-1] ^ io.z_in[AW-2]);

    assign pos = mode_r ? y_r[W-1] : ~z_r[AW-1];
    assign xs  = x_r >>> i;
    assign ys  = y_r >>> i;
    assign ang = atan_tab[i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rdy    <= 1'b0;
            mode_r <= 1'b0;
            i      <= '0;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            ov     <= 1'b0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
        end else begin
            rdy <= 1'b1;
            case (state)
                IDLE: begin
                    if (io.in_valid && rdy) begin
                        mode_r <= io.mode;
                        x_r    <= flip ? -io.x_in : io.x_in;
                        y_r    <= flip ? -io.y_in : io.y_in;
                        z_r    <= {io.z_in[AW-1] ^ flip, io.z_in[AW-2:0]};
                        i      <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x_r <= pos ? x_r - ys : x_r + ys;
                    y_r <= pos ? y_r + xs : y_r - xs;
                    z_r <= pos ? z_r - ang : z_r + ang;
                    i   <= i + 1'b1;
                    if (i == LAST) state <= DONE;
                end
                DONE: begin
                    if (!ov) begin
                        ov  <= 1'b1;
                        x_o <= x_r;
                        y_o <= y_r;
                        z_o <= z_r;
                    end else if (io.out_ready) begin
                        ov    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = rdy && (state == IDLE);
    assign io.busy      = (state != IDLE);
    assign io.out_valid = ov;
    assign io.x_out     = x_o;
    assign io.y_out     = y_o;
    assign io.z_out     = z_o;
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: directed cases, back-pressure, abort by reset,
// and random operands against a bit-level model of the micro-rotation rules.
module tb_cordic_iter_engine;
    localparam int W    = 16;
    localparam int AW   = 16;
    localparam int ITER = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   tab [ITER];

    cordic_iter_engine_if #(.W(W), .AW(AW)) io ();

    cordic_iter_engine #(.W(W), .AW(AW), .ITER(ITER)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input int v, input int n);
        int s;
        s = 32 - n;
        return (v <<< s) >>> s;
    endfunction

    function automatic void model(input bit m, input int xi, input int yi,
                                  input int zi, output int xo, output int yo,
                                  output int zo);
        int x, y, z, d, xn;
        bit fold;
        x = xi;
        y = yi;
        z = zi;
        fold = m ? (x < 0) : (z < -(1 << (AW - 2)) || z >= (1 << (AW - 2)));
        if (fold) begin
            x = wrap(-x, W);
            y = wrap(-y, W);
            z = wrap(z + (1 << (AW - 1)), AW);
        end
        for (int k = 0; k < ITER; k++) begin
            d  = m ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            xn = wrap(x - d * (y >>> k), W);
            y  = wrap(y + d * (x >>> k), W);
            x  = xn;
            z  = wrap(z - d * tab[k], AW);
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic near(input string tag, input int obs, input int exp,
                        input int n);
        int diff;
        diff = wrap(obs - exp, n);
        total++;
        assert (diff <= 4 && diff >= -4) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+/-4", tag, obs, exp);
        end
    endtask

    task automatic start(input bit m, input int x, input int y, input int z);
        @(posedge clk);
        #1;
        io.mode     = m;
        io.x_in     = W'(x);
        io.y_in     = W'(y);
        io.z_in     = AW'(z);
        io.in_valid = 1'b1;
        chk("in_ready_before_accept", int'(io.in_ready), 1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic do_op(input bit m, input int x, input int y, input int z,
                         output int xo, output int yo, output int zo);
        int n, ex, ey, ez;
        start(m, x, y, z);
        n = 0;
        while (io.out_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, ITER + 1);
        xo = int'(io.x_out);
        yo = int'(io.y_out);
        zo = int'(io.z_out);
        model(m, x, y, z, ex, ey, ez);
        chk("x_out", xo, ex);
        chk("y_out", yo, ey);
        chk("z_out", zo, ez);
    endtask

    task automatic consume();
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        chk("out_valid_after_consume", int'(io.out_valid), 0);
        chk("in_ready_after_consume", int'(io.in_ready), 1);
    endtask

    initial begin
        int xo, yo, zo, hx, hy, hz, seen, rx, ry, rz;
        bit rm;
        for (int k = 0; k < ITER; k++)
            tab[k] = $rtoi($atan(1.0 / (2.0 ** k)) * 65536.0
                           / (2.0 * 3.141592653589793) + 0.5);

        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.mode      = 1'b0;
        io.x_in      = '0;
        io.y_in      = '0;
        io.z_in      = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_busy", int'(io.busy), 0);
        chk("rst_in_ready", int'(io.in_ready), 0);
        chk("rst_x_out", int'(io.x_out), 0);
        chk("rst_y_out", int'(io.y_out), 0);
        chk("rst_z_out", int'(io.z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", int'(io.in_ready), 1);

        do_op(1'b0, 4096, 0, 0, xo, yo, zo);
        near("rot0_x", xo, 6745, W);
        near("rot0_y", yo, 0, W);
        near("rot0_z", zo, 0, AW);
        consume();

        do_op(1'b0, 4096, 0, 8192, xo, yo, zo);
        near("rot45_x", xo, 4770, W);
        near("rot45_y", yo, 4770, W);
        near("rot45_z", zo, 0, AW);
        consume();

        do_op(1'b1, 3000, 4000, 0, xo, yo, zo);
        near("vec345_x", xo, 8234, W);
        near("vec345_y", yo, 0, W);
        near("vec345_z", zo, 9672, AW);
        consume();

        do_op(1'b0, 4096, 0, -32768, xo, yo, zo);
        near("rot180_x", xo, -6745, W);
        consume();

        do_op(1'b1, -4096, 0, 0, xo, yo, zo);
        near("vecneg_x", xo, 6745, W);
        near("vecneg_z", zo, -32768, AW);
        consume();

        do_op(1'b1, -32768, 32767, 0, xo, yo, zo);
        consume();

        do_op(1'b0, 1000, -2000, 20000, hx, hy, hz);
        for (int k = 0; k < 10; k++) begin
            io.in_valid = ~io.in_valid;
            io.x_in     = W'($urandom_range(0, 4000));
            @(posedge clk);
            #1;
            chk("bp_x_hold", int'(io.x_out), hx);
            chk("bp_out_valid", int'(io.out_valid), 1);
            chk("bp_in_ready", int'(io.in_ready), 0);
        end
        chk("bp_y_hold", int'(io.y_out), hy);
        chk("bp_z_hold", int'(io.z_out), hz);
        io.in_valid = 1'b0;
        consume();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stray_op", int'(io.busy), 0);

        start(1'b0, 4096, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(io.out_valid), 0);
        chk("abort_busy", int'(io.busy), 0);
        chk("abort_x_out", int'(io.x_out), 0);
        chk("abort_y_out", int'(io.y_out), 0);
        chk("abort_z_out", int'(io.z_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", int'(io.in_ready), 1);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (io.out_valid === 1'b1) seen = 1;
        end
        chk("abort_no_result", seen, 0);

        for (int t = 0; t < 20; t++) begin
            rm = 1'($urandom_range(0, 1));
            rx = int'($urandom_range(0, 16382)) - 8191;
            ry = int'($urandom_range(0, 16382)) - 8191;
            rz = int'($urandom_range(0, 65535)) - 32768;
            do_op(rm, rx, ry, rz, xo, yo, zo);
            consume();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
